imem_fetch: RTL and testbench

//  Consumer end of the PC interface: word-indexed instruction memory plus fetch stage.

---
 rtl/imem_fetch.sv | 92 +++++++++
 tb/tb_imem_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction memory with a stream loader and a one-cycle-latency fetch stage.
// The memory is programmed over load_valid/load_ready, and then the core is released with core_run.
//   state   | meaning
//   ST_LOAD | accepting loader words; fetch disabled, core held
//   ST_RUN  | program loaded; fetch pc every cycle, loader ignored
module imem_fetch #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_run,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] load_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] wptr;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_data;
  logic          load_fire;
  logic          load_done;
  logic          pc_oor;

  assign load_fire = (state == ST_LOAD) && load_valid;
  assign load_done = load_fire && (load_last || (wptr == AW'(DEPTH - 1)));
  // Full-width compare, so that indices at or above DEPTH never alias into the array.
  assign pc_oor    = (pc >= 32'(DEPTH));

  assign load_ready = (state == ST_LOAD);
  assign core_run   = (state == ST_RUN);
  assign instr      = instr_valid ? rd_data : NOP;

  // Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (load_fire && !rst) begin
      mem[wptr] <= load_data;
    end
    if (state == ST_RUN) begin
      rd_data <= mem[pc[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      wptr        <= '0;
      load_count  <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          instr_valid <= 1'b0;
          if (load_fire) begin
            wptr <= wptr + 1'b1;
            if (load_count != 32'(DEPTH)) begin
              load_count <= load_count + 32'd1;
            end
            if (load_done) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          instr_pc    <= pc;
          instr_valid <= !pc_oor && !redirect;
          if (pc_oor) begin
            fault <= 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed load/fetch sequences with random data,
// checked against a word-array reference model of the loader and the fetch rules.
module tb_imem_fetch;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        redirect = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_run;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fault;
  logic [31:0] load_count;

  imem_fetch #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .core_run(core_run), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .fault(fault),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: memory image plus loader progress and the sticky fault.
  logic [31:0] ref_mem [DEPTH];
  int          m_wptr;
  int          m_cnt;
  bit          m_run;
  bit          m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    load_last  = 1'b0;
    redirect   = 1'b0;
    rst        = 1'b1;
    step();
    rst     = 1'b0;
    m_wptr  = 0;
    m_cnt   = 0;
    m_run   = 1'b0;
    m_fault = 1'b0;
  endtask

  // One loader beat; the model writes the word and decides on the move to RUN.
  task automatic load_word(input logic [31:0] data, input bit last, input bit check_ready);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    #1;
    if (check_ready) chk("load_ready", 32'(load_ready), 32'(!m_run));
    step();
    if (!m_run) begin
      ref_mem[m_wptr] = data;
      m_wptr++;
      if (m_cnt < DEPTH) m_cnt++;
      if (last || m_wptr == DEPTH) m_run = 1'b1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p, input bit rd, input string tag);
    logic [31:0] e_instr;
    bit          e_valid;
    pc       = p;
    redirect = rd;
    step();
    if (p >= 32'(DEPTH)) begin
      m_fault = 1'b1;
      e_valid = 1'b0;
      e_instr = NOP;
    end else if (rd) begin
      e_valid = 1'b0;
      e_instr = NOP;
    end else begin
      e_valid = 1'b1;
      e_instr = ref_mem[p];
    end
    redirect = 1'b0;
    chk({tag, ".instr"},    instr,              e_instr);
    chk({tag, ".valid"},    32'(instr_valid),   32'(e_valid));
    chk({tag, ".instr_pc"}, instr_pc,           p);
    chk({tag, ".fault"},    32'(fault),         32'(m_fault));
  endtask

  initial begin
    logic [31:0] wa, wb, wc, wx, p;

    // Reset state
    do_reset();
    chk("rst.load_ready", 32'(load_ready), 32'd1);
    chk("rst.core_run",   32'(core_run),   32'd0);
    chk("rst.instr",      instr,           NOP);
    chk("rst.instr_pc",   instr_pc,        32'd0);
    chk("rst.valid",      32'(instr_valid), 32'd0);
    chk("rst.fault",      32'(fault),      32'd0);
    chk("rst.load_count", load_count,      32'd0);

    // Load A, B, C with load_last on C; a lone load_last without valid is ignored
    wa = $urandom; wb = $urandom; wc = $urandom;
    load_word(wa, 1'b0, 1'b1);
    load_word(wb, 1'b0, 1'b1);
    load_last = 1'b1;
    step();
    load_last = 1'b0;
    chk("t1.last_no_valid.run", 32'(core_run), 32'd0);
    chk("t1.last_no_valid.cnt", load_count,    32'd2);
    load_word(wc, 1'b1, 1'b1);
    chk("t1.core_run",   32'(core_run),    32'(m_run));
    chk("t1.load_count", load_count,       32'(m_cnt));
    chk("t1.load_ready", 32'(load_ready),  32'd0);
    chk("t1.first_run_valid", 32'(instr_valid), 32'd0);

    // Sequential fetch of the loaded program
    fetch(32'd0, 1'b0, "t2.pc0");
    fetch(32'd1, 1'b0, "t2.pc1");
    fetch(32'd2, 1'b0, "t2.pc2");

    // Redirect squashes, next fetch is valid again
    fetch(32'd1, 1'b1, "t3.redir");
    fetch(32'd0, 1'b0, "t3.after");

    // Random fetches and redirects in the loaded range; loader ignored while running
    for (int i = 0; i < 20; i++) begin
      load_valid = $urandom_range(0, 1);
      load_data  = $urandom;
      fetch(32'($urandom_range(0, 2)), bit'($urandom_range(0, 3) == 0), "t3.rand");
      chk("t3.rand.load_count", load_count, 32'(m_cnt));
    end
    load_valid = 1'b0;

    // Out-of-range fetch sets a sticky fault
    fetch(32'(DEPTH), 1'b0, "t4.oor");
    fetch(32'd0, 1'b0, "t4.after0");
    fetch(32'($urandom) | 32'h8000_0000, 1'b1, "t4.oor_redir");
    fetch(32'd2, 1'b0, "t4.after2");

    // Stream DEPTH words without load_last
    do_reset();
    chk("t5.rst.fault", 32'(fault), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      load_word($urandom, 1'b0, (i % 64) == 0 || i == DEPTH - 1);
      if (i == DEPTH - 2) chk("t5.run_early", 32'(core_run), 32'd0);
    end
    chk("t5.core_run",   32'(core_run), 32'd1);
    chk("t5.load_count", load_count,    32'(DEPTH));
    load_word($urandom, 1'b0, 1'b1);
    chk("t5.extra.load_count", load_count, 32'(DEPTH));
    for (int i = 0; i < 30; i++) begin
      p = 32'($urandom_range(0, DEPTH - 1));
      if (i == 0) p = 32'(DEPTH - 1);
      fetch(p, bit'($urandom_range(0, 4) == 0), "t5.rand");
    end

    // Reset mid-load: old memory contents survive
    do_reset();
    load_word($urandom, 1'b0, 1'b1);
    load_word($urandom, 1'b0, 1'b1);
    chk("t6.mid.count", load_count, 32'd2);
    do_reset();
    chk("t6.rst.count", load_count, 32'd0);
    wx = $urandom;
    load_word(wx, 1'b1, 1'b1);
    chk("t6.core_run", 32'(core_run), 32'd1);
    fetch(32'd0, 1'b0, "t6.pc0");
    chk("t6.x", instr, wx);
    fetch(32'd1, 1'b0, "t6.pc1_old");
    fetch(32'd5, 1'b0, "t6.pc5_old");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
